// File: rtl/fetch_issue_if.sv
// Fetch/issue bus: instruction-memory request channel plus the decode-facing issue channel.
`timescale 1ns/1ps
interface fetch_issue_if #(
   parameter int IW = 16,
   parameter int AW = 8
);
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [IW-1:0] imem_rdata;
   logic          ir_valid;
   logic          ir_ready;
   logic [IW-1:0] ir_instr;
   logic [3:0]    ir_opcode;
   logic [AW-1:0] ir_pc;
   logic          ir_illegal;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output ir_valid, ir_instr, ir_opcode, ir_pc, ir_illegal,
      input  ir_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  ir_valid, ir_instr, ir_opcode, ir_pc, ir_illegal,
      output ir_ready
   );
endinterface

// File: rtl/fetch_issue.sv
// Instruction fetch/issue: walks a PC, fetches over req/ack, buffers words in a small
// FIFO for decode, and flushes buffered and in-flight words on a branch redirect.
`timescale 1ns/1ps
module fetch_issue #(
   parameter int            IW       = 16,
   parameter int            AW       = 8,
   parameter int            DEPTH    = 2,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   fetch_issue_if.master bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] pc, pc_nxt, addr;
   logic [IW-1:0] instr_mem [DEPTH];
   logic [AW-1:0] pc_mem    [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic [CW:0]   cnt_after;
   logic [IW-1:0] head_instr;
   logic          empty, push, pop, room;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   function automatic logic legal_op(input logic [3:0] op);
      case (op)
         4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hC: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Redirect overrides both FIFO ports; the flush leaves room for the refetch.
   assign empty     = (count == '0);
   assign push      = (state == REQ) && bus.imem_ack && !redirect;
   assign pop       = !empty && bus.ir_ready && !redirect;
   assign cnt_after = (CW+1)'(count) + (CW+1)'(push) - (CW+1)'(pop);
   assign room      = redirect || (cnt_after < (CW+1)'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!redirect && en && room) state_nxt = REQ;
         end
         REQ: begin
            if (redirect && !bus.imem_ack) state_nxt = DISCARD;
            else if (bus.imem_ack)         state_nxt = (en && room) ? REQ : IDLE;
         end
         DISCARD: begin
            if (bus.imem_ack) state_nxt = (en && room) ? REQ : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      head_instr     = empty ? '0 : instr_mem[rd_ptr];
      bus.imem_req   = (state != IDLE);
      bus.imem_addr  = addr;
      bus.ir_valid   = !empty;
      bus.ir_instr   = head_instr;
      bus.ir_opcode  = head_instr[IW-1:IW-4];
      bus.ir_pc      = empty ? '0 : pc_mem[rd_ptr];
      bus.ir_illegal = !empty && !legal_op(head_instr[IW-1:IW-4]);
   end

   always_comb begin
      pc_nxt = pc;
      if (redirect)  pc_nxt = redirect_pc;
      else if (push) pc_nxt = pc + AW'(1);
   end

   // addr latches only when a new request starts, so a DISCARD keeps the stale address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc   <= RESET_PC;
         addr <= RESET_PC;
      end else begin
         pc <= pc_nxt;
         if (state_nxt == REQ) addr <= pc_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= inc(wr_ptr);
         if (pop)  rd_ptr <= inc(rd_ptr);
         count <= cnt_after[CW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= bus.imem_rdata;
         pc_mem[wr_ptr]    <= pc;
      end
   end
endmodule

// File: tb/tb_fetch_issue.sv
// Bench for fetch_issue: memory responder, scoreboard of expected issued words, directed scenarios.
`timescale 1ns/1ps
module tb_fetch_issue;
   localparam int IW = 16;
   localparam int AW = 8;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [IW-1:0] instr;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0, en = 1'b0, redirect = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          rst2_n = 1'b0, en2 = 1'b0, redirect2 = 1'b0;
   logic [AW-1:0] redirect_pc2 = '0;

   int n_tests = 0, n_fail = 0;
   logic [IW-1:0] mem [256];
   exp_t q[$];
   logic [AW-1:0] exp_addr = '0;
   logic stale = 1'b0;
   logic auto_ack = 1'b1;
   int   ack_delay = 1, wait_cnt = 0, man_req = 0, man_done = 0;

   always #5 clk = ~clk;

   fetch_issue_if #(.IW(IW), .AW(AW)) bus ();
   fetch_issue_if #(.IW(IW), .AW(AW)) bus2 ();

   fetch_issue #(.IW(IW), .AW(AW), .DEPTH(2), .RESET_PC(8'h00)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .redirect(redirect),
      .redirect_pc(redirect_pc), .bus(bus)
   );

   fetch_issue #(.IW(IW), .AW(AW), .DEPTH(2), .RESET_PC(8'hFF)) u_dut_ff (
      .clk(clk), .rst_n(rst2_n), .en(en2), .redirect(redirect2),
      .redirect_pc(redirect_pc2), .bus(bus2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic exp_illegal(input logic [3:0] op);
      case (op)
         4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hC: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_req(input string tag);
      int i = 0;
      while (!bus.imem_req && i < 50) begin step(); i++; end
      if (i >= 50) chk({tag, "_timeout"}, 0, 1);
   endtask

   task automatic wait_addr(input int a);
      int i = 0;
      while (int'(exp_addr) < a && i < 400) begin step(); i++; end
      if (i >= 400) chk("fetch_timeout", exp_addr, a);
   endtask

   task automatic drain();
      int i = 0;
      en = 1'b0;
      bus.ir_ready = 1'b1;
      while ((q.size() != 0 || bus.imem_req) && i < 200) begin step(); i++; end
      if (i >= 200) chk("drain_timeout", q.size(), 0);
      step();
      chk("drained_valid", bus.ir_valid, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step();
   endtask

   // Memory responder: auto mode acks after ack_delay cycles, manual mode on request count.
   initial begin
      bus.imem_ack = 1'b0;
      bus.imem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.imem_ack) bus.imem_ack = 1'b0;
         else if (rst_n && bus.imem_req && !auto_ack && man_req != man_done) begin
            bus.imem_ack = 1'b1;
            bus.imem_rdata = mem[bus.imem_addr];
            man_done++;
         end else if (rst_n && bus.imem_req && auto_ack) begin
            if (wait_cnt >= ack_delay) begin
               bus.imem_ack = 1'b1;
               bus.imem_rdata = mem[bus.imem_addr];
               wait_cnt = 0;
            end else wait_cnt++;
         end else wait_cnt = 0;
      end
   end

   // Reference model and scoreboard, sampled mid-cycle ahead of the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            stale = 1'b0;
            exp_addr = '0;
         end else begin
            if (bus.imem_ack && bus.imem_req) begin
               if (stale) stale = 1'b0;
               else if (!redirect) begin
                  chk("imem_addr", bus.imem_addr, exp_addr);
                  q.push_back('{pc: exp_addr, instr: mem[exp_addr]});
                  exp_addr = exp_addr + 1'b1;
               end
            end else if (redirect && bus.imem_req) stale = 1'b1;
            if (redirect) begin
               q.delete();
               exp_addr = redirect_pc;
            end else if (bus.ir_valid && bus.ir_ready) begin
               if (q.size() == 0) chk("spurious_issue", bus.ir_pc, 32'hFFFF_FFFF);
               else begin
                  e = q.pop_front();
                  chk("ir_pc", bus.ir_pc, e.pc);
                  chk("ir_instr", bus.ir_instr, e.instr);
                  chk("ir_opcode", bus.ir_opcode, e.instr[IW-1:IW-4]);
                  chk("ir_illegal", bus.ir_illegal, exp_illegal(e.instr[IW-1:IW-4]));
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      logic any_valid;
      for (int a = 0; a < 256; a++) mem[a] = {4'(a), 4'h5, 8'(a)};
      mem[0] = 16'h1123; mem[1] = 16'h2210; mem[2] = 16'hC300;
      mem[3] = 16'hF000; mem[4] = 16'h0000;
      bus.ir_ready = 1'b0;
      bus2.ir_ready = 1'b0;
      bus2.imem_ack = 1'b0;
      bus2.imem_rdata = '0;
      step(3);

      // reset state
      chk("rst_req", bus.imem_req, 0);
      chk("rst_addr", bus.imem_addr, 8'h00);
      chk("rst_valid", bus.ir_valid, 0);
      chk("rst_instr", bus.ir_instr, 0);
      chk("rst_opcode", bus.ir_opcode, 0);
      chk("rst_pc", bus.ir_pc, 0);
      chk("rst_illegal", bus.ir_illegal, 0);
      rst_n = 1'b1;
      step();

      // in-order fetch/issue, opcodes 0..F including F000 and NOP
      en = 1'b1;
      bus.ir_ready = 1'b1;
      wait_addr(20);
      for (int k = 0; k < 80; k++) begin
         bus.ir_ready = 1'($urandom_range(0, 1));
         ack_delay = int'($urandom_range(0, 2));
         step();
      end
      ack_delay = 1;
      drain();

      // back-pressure: two words buffered, fetch stalls, then resumes at addr 2
      do_reset();
      bus.ir_ready = 1'b0;
      en = 1'b1;
      step(12);
      chk("bp_req", bus.imem_req, 0);
      chk("bp_fetched", exp_addr, 2);
      chk("bp_valid", bus.ir_valid, 1);
      chk("bp_instr", bus.ir_instr, 16'h1123);
      step(3);
      chk("bp_hold", bus.ir_instr, 16'h1123);
      chk("bp_hold_pc", bus.ir_pc, 0);
      bus.ir_ready = 1'b1;
      wait_req("bp_resume");
      chk("bp_resume_addr", bus.imem_addr, 8'h02);
      drain();

      // redirect while a request is outstanding: stale data dropped
      do_reset();
      auto_ack = 1'b0;
      bus.ir_ready = 1'b1;
      redirect = 1'b1; redirect_pc = 8'h05;
      step();
      redirect = 1'b0;
      en = 1'b1;
      step(3);
      chk("rd_req", bus.imem_req, 1);
      chk("rd_addr5", bus.imem_addr, 8'h05);
      redirect = 1'b1; redirect_pc = 8'h40;
      step();
      redirect = 1'b0;
      chk("rd_discard_req", bus.imem_req, 1);
      chk("rd_discard_addr", bus.imem_addr, 8'h05);
      any_valid = 1'b0;
      step();
      any_valid |= bus.ir_valid;
      man_req++;
      for (int k = 0; k < 3; k++) begin step(); any_valid |= bus.ir_valid; end
      chk("rd_no_valid", any_valid, 0);
      wait_req("rd_refetch");
      chk("rd_refetch_addr", bus.imem_addr, 8'h40);
      auto_ack = 1'b1;
      i = 0;
      while (!bus.ir_valid && i < 50) begin step(); i++; end
      chk("rd_first_pc", bus.ir_pc, 8'h40);
      drain();

      // redirect in the same cycle as the ack of addr 7
      auto_ack = 1'b0;
      redirect = 1'b1; redirect_pc = 8'h07;
      step();
      redirect = 1'b0;
      en = 1'b1;
      wait_req("ra_req");
      chk("ra_addr7", bus.imem_addr, 8'h07);
      man_req++;
      step();
      redirect = 1'b1; redirect_pc = 8'h20;
      step();
      redirect = 1'b0;
      chk("ra_valid", bus.ir_valid, 0);
      wait_req("ra_refetch");
      chk("ra_refetch_addr", bus.imem_addr, 8'h20);
      auto_ack = 1'b1;
      i = 0;
      while (!bus.ir_valid && i < 50) begin step(); i++; end
      chk("ra_first_pc", bus.ir_pc, 8'h20);
      drain();

      // RESET_PC = FF: wrap, and reset while a request is waiting
      en2 = 1'b1;
      rst2_n = 1'b1;
      i = 0;
      while (!bus2.imem_req && i < 20) begin step(); i++; end
      chk("ff_req", bus2.imem_req, 1);
      chk("ff_addr", bus2.imem_addr, 8'hFF);
      bus2.imem_ack = 1'b1;
      bus2.imem_rdata = 16'h1234;
      step();
      bus2.imem_ack = 1'b0;
      i = 0;
      while (!bus2.imem_req && i < 20) begin step(); i++; end
      chk("ff_wrap_addr", bus2.imem_addr, 8'h00);
      chk("ff_valid", bus2.ir_valid, 1);
      chk("ff_pc", bus2.ir_pc, 8'hFF);
      step(2);
      rst2_n = 1'b0;
      #1;
      chk("ff_rst_req", bus2.imem_req, 0);
      chk("ff_rst_valid", bus2.ir_valid, 0);
      step();
      rst2_n = 1'b1;
      i = 0;
      while (!bus2.imem_req && i < 20) begin step(); i++; end
      chk("ff_restart_addr", bus2.imem_addr, 8'hFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
